bcd_updown_counter_n: RTL and testbench
=======================================

// Module: bcd_updown_counter_n
// PURPOSE
//  Registered multi-digit BCD up/down counter with synchronous load, hold and carry/borrow.
//  It is the clocked, parametrised successor of the single-digit combinational BCD step cell.
//  Sits behind keypad/seven-segment front ends as the decimal counting core.
//  The cascade output tc lets several instances chain.
// PARAMETERS
//  DIGITS  4  number of BCD digits; value width is 4*DIGITS
//  WRAP    1  1: wrap at terminal count; 0: saturate (hold) at terminal count
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         synchronous, active-high reset
//  en          in   1         count enable, sampled on clk
//  dir         in   1         1 = count up, 0 = count down
//  load        in   1         synchronous load strobe
//  inputs      in   4*DIGITS  load value, BCD, digit 0 in [3:0]
//  outputs     out  4*DIGITS  registered count value, BCD
//  cout        out  1         registered; 1-cycle pulse on wrap/saturation event
//  tc          out  1         combinational terminal count for cascading
// BEHAVIOUR
//  - Reset: when rst=1 at a posedge, outputs=0 and cout=0.
//    rst has priority over every other input, including mid-count.
//  - Priority per posedge: rst > load > en. When all three are 0: hold, cout=0.
//  - Load: outputs <= inputs digit by digit. Any input digit >9 loads as 0.
//    cout <= 0. en is ignored in a load cycle.
//  - Up count (en=1, dir=1):
//    - Digit k increments when all lower digits are 9.
//    - Any digit that is 9 and steps rolls to 0.
//  - Up at all-9s:
//    - WRAP=1: outputs <= 0, cout <= 1.
//    - WRAP=0: outputs hold all-9s, cout <= 1 on every such enabled cycle.
//  - Down count (en=1, dir=0):
//    - Digit k decrements when all lower digits are 0.
//    - Any digit that is 0 and steps rolls to 9.
//  - Down at all-0s:
//    - WRAP=1: outputs <= all-9s, cout <= 1.
//    - WRAP=0: outputs hold 0, cout <= 1.
//  - cout is 0 in every cycle except those listed above. It is never set by load or reset.
//  - tc = en & ((dir & outputs==all-9s) | (~dir & outputs==0)). It is purely combinational.
//    It is the enable for the next-higher instance.
//  - Latency: outputs and cout change one posedge after en/load is sampled.
//  - The counter never holds a non-BCD digit: invalid digits are only reachable via load,
//    and load sanitises them.
//  - A dir change takes effect at the next enabled edge. There is no pipeline state.
// TESTING (DIGITS=2 unless noted)
//  1. rst=1 for 1 clk with en=1, load=1 -> outputs=8'h00, cout=0.
//  2. load inputs=8'h09, then en=1 dir=1 for 2 clks -> 8'h10, then 8'h11; cout=0 throughout.
//  3. load 8'h99, en=1 dir=1 -> 8'h00 with cout=1 for exactly 1 cycle.
//     Before that edge tc=1; cout=0 on the following cycle.
//  4. load 8'h00, en=1 dir=0 -> 8'h99 with cout=1; next edge -> 8'h98 with cout=0.
//  5. load inputs=8'hA7 -> outputs=8'h07; load=1 together with en=1 -> load wins.
//  6. WRAP=0: load 8'h99, en=1 dir=1 for 3 clks -> holds 8'h99, cout=1 each cycle.
//     Then dir=0 -> 8'h98, cout=0.
//     Finally rst=1 mid-count -> 8'h00.

Source files
------------

// File: rtl/bcd_updown_counter_n.sv
// Registered DIGITS-wide BCD up/down counter with load, wrap or saturate, and cascade tc.
// Latency 1 clk for outputs/cout and combinational tc; no backpressure, en simply gates counting.
module bcd_updown_counter_n #(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   inputs,
  output logic [4*DIGITS-1:0]   outputs,
  output logic                  cout,
  output logic                  tc
);

  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] load_val;
  logic                all9;
  logic                all0;
  logic                at_term;
  logic                carry;
  logic                borrow;
  logic [3:0]          dig;
  logic [3:0]          ldig;

  // Ripple through the digits; a carry/borrow surviving the top digit means all-9s / all-0s.
  always_comb begin
    inc_val  = outputs;
    dec_val  = outputs;
    load_val = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    dig      = 4'd0;
    ldig     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = outputs[4*k +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      ldig = inputs[4*k +: 4];
      load_val[4*k +: 4] = (ldig > 4'd9) ? 4'd0 : ldig;
    end
    all9 = carry;
    all0 = borrow;
  end

  assign at_term = dir ? all9 : all0;
  assign tc      = en & at_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      outputs <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      outputs <= load_val;
      cout    <= 1'b0;
    end else if (en) begin
      cout <= at_term;
      if (!(at_term && (WRAP == 0))) begin
        outputs <= dir ? inc_val : dec_val;
      end
    end else begin
      cout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: wrap and saturate instances share stimulus, checked
// against an integer-valued reference model.
module tb_bcd_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [7:0] inputs;
  logic [7:0] out_w, out_s;
  logic       cout_w, cout_s, tc_w, tc_s;

  int n_chk  = 0;
  int n_fail = 0;
  int mv_w   = 0;
  int mv_s   = 0;
  bit mc_w   = 0;
  bit mc_s   = 0;
  bit valid  = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(2), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .inputs(inputs), .outputs(out_w), .cout(cout_w), .tc(tc_w)
  );

  bcd_updown_counter_n #(.DIGITS(2), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .inputs(inputs), .outputs(out_s), .cout(cout_s), .tc(tc_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit ref_tc(input int v);
    ref_tc = en && (dir ? (v == 99) : (v == 0));
  endfunction

  // Counter value as a plain integer 0..99; digits only matter at load time.
  task automatic ref_step(input int v, input bit wrap, output int nv, output bit nc);
    int hi, lo;
    nv = v;
    nc = 1'b0;
    if (rst) begin
      nv = 0;
    end else if (load) begin
      lo = (int'(inputs[3:0]) > 9) ? 0 : int'(inputs[3:0]);
      hi = (int'(inputs[7:4]) > 9) ? 0 : int'(inputs[7:4]);
      nv = hi * 10 + lo;
    end else if (en) begin
      if (dir) begin
        if (v == 99) begin nc = 1'b1; nv = wrap ? 0 : 99; end
        else nv = v + 1;
      end else begin
        if (v == 0) begin nc = 1'b1; nv = wrap ? 99 : 0; end
        else nv = v - 1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit l, input bit e, input bit d, input logic [7:0] in);
    int nw, ns;
    bit cw, cs;
    rst = r; load = l; en = e; dir = d; inputs = in;
    #1;
    if (valid) begin
      check("tc_wrap", {31'd0, tc_w}, {31'd0, ref_tc(mv_w)});
      check("tc_sat",  {31'd0, tc_s}, {31'd0, ref_tc(mv_s)});
    end
    ref_step(mv_w, 1'b1, nw, cw);
    ref_step(mv_s, 1'b0, ns, cs);
    @(posedge clk);
    if (r) valid = 1'b1;
    mv_w = nw; mc_w = cw;
    mv_s = ns; mc_s = cs;
    #1;
    if (valid) begin
      check("out_wrap",  {24'd0, out_w}, {24'd0, to_bcd(mv_w)});
      check("cout_wrap", {31'd0, cout_w}, {31'd0, mc_w});
      check("out_sat",   {24'd0, out_s}, {24'd0, to_bcd(mv_s)});
      check("cout_sat",  {31'd0, cout_s}, {31'd0, mc_s});
    end
  endtask

  initial begin
    logic [7:0] lv;
    int         sel;
    rst = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; inputs = 8'h00;

    // reset beats load and en
    cycle(1, 1, 1, 1, 8'h55);
    check("t1_out", {24'd0, out_w}, 32'h00);
    check("t1_cout", {31'd0, cout_w}, 32'd0);

    // 09 -> 10 -> 11
    cycle(0, 1, 0, 0, 8'h09);
    cycle(0, 0, 1, 1, 8'h00);
    check("t2_first", {24'd0, out_w}, 32'h10);
    cycle(0, 0, 1, 1, 8'h00);
    check("t2_second", {24'd0, out_w}, 32'h11);

    // up wrap at 99
    cycle(0, 1, 0, 0, 8'h99);
    cycle(0, 0, 1, 1, 8'h00);
    check("t3_wrap", {24'd0, out_w}, 32'h00);
    check("t3_cout", {31'd0, cout_w}, 32'd1);
    cycle(0, 0, 0, 1, 8'h00);
    check("t3_cout_drop", {31'd0, cout_w}, 32'd0);

    // down wrap at 00
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    check("t4_wrap", {24'd0, out_w}, 32'h99);
    cycle(0, 0, 1, 0, 8'h00);
    check("t4_next", {24'd0, out_w}, 32'h98);

    // invalid digit sanitised, load wins over en
    cycle(0, 1, 1, 1, 8'hA7);
    check("t5_sanitize", {24'd0, out_w}, 32'h07);

    // saturating instance holds 99 while pulsing cout
    cycle(0, 1, 0, 0, 8'h99);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 1, 8'h00);
      check("t6_hold", {24'd0, out_s}, 32'h99);
      check("t6_cout", {31'd0, cout_s}, 32'd1);
    end
    cycle(0, 0, 1, 0, 8'h00);
    check("t6_down", {24'd0, out_s}, 32'h98);
    cycle(1, 0, 1, 0, 8'h00);
    check("t6_rst", {24'd0, out_s}, 32'h00);

    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: lv = 8'h99;
        1: lv = 8'h00;
        2: lv = 8'h90;
        3: lv = 8'h09;
        default: lv = 8'($urandom);
      endcase
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), lv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
